// File: rtl/lcd_bus_reader_pkg.sv
// Shared LCD bus types: controller state enum and default timing.
// Also used by the LCD write controller.
package lcd_bus_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EHIGH,
    ELOW,
    DONE
  } lcd_state_t;

  localparam int CNT_W         = 8;
  localparam int LCD_T_AS      = 3;
  localparam int LCD_T_EH      = 12;
  localparam int LCD_T_EL      = 13;
  localparam int LCD_MAX_POLLS = 255;

  // A phase of N cycles loads N-1 and ends on the zero flag.
  function automatic logic [CNT_W-1:0] ld_val(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Host-side request/result bundle of the LCD bus reader.
// master: requester (start, rs, poll); slave: reader results.
interface lcd_bus_reader_if (
  input logic clk
);

  logic       start;
  logic       rs;
  logic       poll;
  logic       ready;
  logic       done;
  logic [7:0] data;
  logic       busy_flag;
  logic [6:0] addr;
  logic       timeout;

  modport master (
    input  clk, ready, done, data,
    input  busy_flag, addr, timeout,
    output start, rs, poll
  );

  modport slave (
    input  clk, start, rs, poll,
    output ready, done, data,
    output busy_flag, addr, timeout
  );

endinterface

// File: rtl/lcd_strobe_timer.sv
// Loadable down-counter shared by all LCD strobe phases.
// Ports: clk, rst_n, load, load_val in; zero flag out.
import lcd_bus_reader_pkg::*;

module lcd_strobe_timer (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780-style bus reader: status/data reads, optional BF polling.
// Ports: host request/result, LCD_RW/E/RS strobes, DATA_BUS (never driven).
import lcd_bus_reader_pkg::*;

module lcd_bus_reader #(
  parameter int T_AS      = LCD_T_AS,
  parameter int T_EH      = LCD_T_EH,
  parameter int T_EL      = LCD_T_EL,
  parameter int MAX_POLLS = LCD_MAX_POLLS
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic       oReady,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       oBusyFlag,
  output logic [6:0] oAddr,
  output logic       oTimeout,
  inout  wire  [7:0] DATA_BUS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       LCD_RS
);

  localparam logic [7:0] MAXP = 8'(MAX_POLLS);

  lcd_state_t       state;
  lcd_state_t       nxt;
  logic             poll_q;
  logic [7:0]       polls;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;
  logic             retry;
  logic             accept;
  logic             e_fall;

  // Reads only: the pins stay released at all times.
  assign DATA_BUS = 8'bzzzz_zzzz;

  assign accept = (state == IDLE) && iStart;
  assign e_fall = (state == EHIGH) && tmr_zero;

  lcd_strobe_timer u_tmr (
    .clk      (iCLK_50MHZ),
    .rst_n    (iRST_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    retry    = 1'b0;
    unique case (state)
      IDLE: begin
        if (iStart) begin
          nxt      = SETUP;
          tmr_load = 1'b1;
          tmr_val  = ld_val(T_AS);
        end
      end
      SETUP: begin
        if (tmr_zero) begin
          nxt      = EHIGH;
          tmr_load = 1'b1;
          tmr_val  = ld_val(T_EH);
        end
      end
      EHIGH: begin
        if (tmr_zero) begin
          nxt      = ELOW;
          tmr_load = 1'b1;
          tmr_val  = ld_val(T_EL);
        end
      end
      ELOW: begin
        if (tmr_zero) begin
          // oBusyFlag already holds this read's BF
          if (poll_q && oBusyFlag && (polls < MAXP)) begin
            nxt      = SETUP;
            tmr_load = 1'b1;
            tmr_val  = ld_val(T_AS);
            retry    = 1'b1;
          end else begin
            nxt = DONE;
          end
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      poll_q <= 1'b0;
      polls  <= '0;
      LCD_RS <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        LCD_RS <= iRS;
        // a data read never polls
        poll_q <= iPoll & ~iRS;
        polls  <= '0;
      end else if (retry) begin
        polls <= polls + 1'b1;
      end
    end
  end

  // Strobes and flags are flops decoded from the next state.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      LCD_E    <= 1'b0;
      LCD_RW   <= 1'b0;
      oReady   <= 1'b1;
      oDone    <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      LCD_E    <= (nxt == EHIGH);
      LCD_RW   <= nxt inside {SETUP, EHIGH, ELOW};
      oReady   <= (nxt == IDLE);
      oDone    <= (nxt == DONE);
      oTimeout <= (state == ELOW) && (nxt == DONE)
                  && poll_q && oBusyFlag;
    end
  end

  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      oData     <= '0;
      oBusyFlag <= 1'b0;
      oAddr     <= '0;
    end else if (e_fall) begin
      oData <= DATA_BUS;
      if (!LCD_RS) begin
        oBusyFlag <= DATA_BUS[7];
        oAddr     <= DATA_BUS[6:0];
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Self-checking bench for lcd_bus_reader: vector table,
// corner sequences and randomized reads against a reference model.
module tb_lcd_bus_reader;
  import lcd_bus_reader_pkg::*;

  localparam int MAXP = 4;
  localparam int TXN  = LCD_T_AS + LCD_T_EH + LCD_T_EL;

  typedef struct {
    bit         rs;
    bit         poll;
    int         nbusy;
    logic [7:0] fin;
    int         pulses;
    logic [7:0] data;
    bit         bf;
    logic [6:0] addr;
    bit         tmo;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  lcd_bus_reader_if host (clk);

  wire  [7:0] data_bus;
  logic [7:0] bus_val = 8'h00;
  assign data_bus = bus_val;

  logic lcd_rw, lcd_e, lcd_rs;

  lcd_bus_reader #(.MAX_POLLS(MAXP)) dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .iStart     (host.start),
    .iRS        (host.rs),
    .iPoll      (host.poll),
    .oReady     (host.ready),
    .oDone      (host.done),
    .oData      (host.data),
    .oBusyFlag  (host.busy_flag),
    .oAddr      (host.addr),
    .oTimeout   (host.timeout),
    .DATA_BUS   (data_bus),
    .LCD_RW     (lcd_rw),
    .LCD_E      (lcd_e),
    .LCD_RS     (lcd_rs)
  );

  int n_chk = 0;
  int n_fail = 0;

  // bus model: one response byte per E pulse
  logic [7:0] resp [16];
  int n_pulse = 0;
  int pbase = 0;
  always @(posedge lcd_e) begin
    int idx;
    idx = n_pulse - pbase;
    if (idx > 15) idx = 15;
    bus_val = resp[idx];
    n_pulse++;
  end

  // E width and RS stability monitor
  int run = 0;
  int wbad = 0;
  int rsbad = 0;
  logic exp_rs = 1'b0;
  always @(negedge clk) begin
    if (lcd_e) begin
      run++;
    end else if (run != 0) begin
      if (run != LCD_T_EH) wbad++;
      run = 0;
    end
    if (lcd_rw && lcd_rs !== exp_rs) rsbad++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rbyte(input int i, input int nbusy,
                                       input logic [7:0] fin);
    return (i < nbusy) ? (8'h80 | 8'(i)) : fin;
  endfunction

  task automatic fill(input int nbusy, input logic [7:0] fin);
    for (int i = 0; i < 16; i++) resp[i] = rbyte(i, nbusy, fin);
    pbase = n_pulse;
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int n, pb, wb, rb;
    fill(v.nbusy, v.fin);
    pb = n_pulse;
    wb = wbad;
    rb = rsbad;
    exp_rs = v.rs;
    @(negedge clk);
    host.start = 1'b1;
    host.rs    = v.rs;
    host.poll  = v.poll;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    host.start = 1'b0;
    host.rs    = 1'($urandom);
    host.poll  = 1'($urandom);
    while (host.done !== 1'b1 && n < 1000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, " latency"}, n + 1, v.lat);
    chk({tag, " data"}, host.data, v.data);
    chk({tag, " busy"}, host.busy_flag, v.bf);
    chk({tag, " addr"}, host.addr, v.addr);
    chk({tag, " timeout"}, host.timeout, v.tmo);
    chk({tag, " rw_done"}, lcd_rw, 0);
    chk({tag, " pulses"}, n_pulse - pb, v.pulses);
    @(negedge clk);
    chk({tag, " done_1cyc"}, host.done, 0);
    chk({tag, " tmo_1cyc"}, host.timeout, 0);
    chk({tag, " ready"}, host.ready, 1);
    chk({tag, " e_width"}, wbad - wb, 0);
    chk({tag, " rs_hold"}, rsbad - rb, 0);
  endtask

  vec_t tbl[6];
  vec_t rv;
  bit   m_bf;
  logic [6:0] m_addr;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int t, k, pb;
    int d[3];
    logic [7:0] b;
    int reads;
    bit more;

    tbl[0] = '{1'b0, 1'b0, 0,  8'h85, 1, 8'h85, 1'b1, 7'h05, 1'b0, 30};
    tbl[1] = '{1'b1, 1'b0, 0,  8'h41, 1, 8'h41, 1'b1, 7'h05, 1'b0, 30};
    tbl[2] = '{1'b0, 1'b1, 3,  8'h00, 4, 8'h00, 1'b0, 7'h00, 1'b0, 114};
    tbl[3] = '{1'b0, 1'b1, 10, 8'h80, 5, 8'h84, 1'b1, 7'h04, 1'b1, 142};
    tbl[4] = '{1'b1, 1'b1, 0,  8'hC5, 1, 8'hC5, 1'b1, 7'h04, 1'b0, 30};
    tbl[5] = '{1'b0, 1'b1, 0,  8'h2A, 1, 8'h2A, 1'b0, 7'h2A, 1'b0, 30};

    host.start = 1'b0;
    host.rs    = 1'b0;
    host.poll  = 1'b0;
    for (int i = 0; i < 16; i++) resp[i] = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst ready", host.ready, 1);
    chk("rst done", host.done, 0);
    chk("rst data", host.data, 0);
    chk("rst busy", host.busy_flag, 0);
    chk("rst addr", host.addr, 0);
    chk("rst timeout", host.timeout, 0);
    chk("rst e", lcd_e, 0);
    chk("rst rw", lcd_rw, 0);
    chk("rst rs", lcd_rs, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle ready", host.ready, 1);

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), tbl[i]);

    // iStart held high: back-to-back reads
    fill(0, 8'h41);
    pb = n_pulse;
    exp_rs = 1'b1;
    @(negedge clk);
    host.start = 1'b1;
    host.rs    = 1'b1;
    host.poll  = 1'b0;
    t = 0;
    k = 0;
    while (k < 3 && t < 400) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      if (host.done === 1'b1) begin
        d[k] = t;
        k++;
      end
    end
    host.start = 1'b0;
    chk("b2b dones", k, 3);
    chk("b2b gap0", d[1] - d[0], TXN + 2);
    chk("b2b gap1", d[2] - d[1], TXN + 2);
    repeat (3) @(negedge clk);
    chk("b2b pulses", n_pulse - pb, 3);
    chk("b2b data", host.data, 8'h41);

    // reset during the 5th EHIGH cycle
    fill(0, 8'h85);
    exp_rs = 1'b0;
    @(negedge clk);
    host.start = 1'b1;
    host.rs    = 1'b0;
    @(negedge clk);
    host.start = 1'b0;
    t = 0;
    while (lcd_e !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("abort e_rise", lcd_e, 1);
    repeat (4) @(posedge clk);
    #5;
    chk("abort pre_e", lcd_e, 1);
    rst_n = 1'b0;
    #1;
    chk("abort e", lcd_e, 0);
    chk("abort rw", lcd_rw, 0);
    chk("abort ready", host.ready, 1);
    chk("abort done", host.done, 0);
    chk("abort data", host.data, 0);
    chk("abort addr", host.addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pb = n_pulse;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host.done === 1'b1) k++;
    end
    chk("abort no_done", k, 0);
    chk("abort no_e", n_pulse - pb, 0);
    chk("abort idle", host.ready, 1);

    // randomized reads vs reference model
    m_bf   = 1'b0;
    m_addr = 7'h00;
    for (int r = 0; r < 24; r++) begin
      rv.rs    = 1'($urandom);
      rv.poll  = 1'($urandom);
      rv.nbusy = int'($urandom_range(0, 6));
      rv.fin   = 8'($urandom);
      reads = 0;
      do begin
        b = rbyte(reads, rv.nbusy, rv.fin);
        reads++;
        if (!rv.rs) begin
          m_bf   = b[7];
          m_addr = b[6:0];
        end
        more = rv.poll && !rv.rs && b[7] && (reads - 1 < MAXP);
      end while (more);
      rv.pulses = reads;
      rv.data   = b;
      rv.bf     = m_bf;
      rv.addr   = m_addr;
      rv.tmo    = rv.poll && !rv.rs && b[7];
      rv.lat    = reads * TXN + 2;
      run_txn($sformatf("rnd%0d", r), rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_reader.md
LCD_BUS_READER -- requirements
Module: lcd_bus_reader

Interface
REQ-001 SHALL have parameter T_AS, default 3, clocks of RS/RW setup before E rises (60 ns at 50 MHz).
REQ-002 SHALL have parameter T_EH, default 12, clocks E held high (240 ns).
REQ-003 SHALL have parameter T_EL, default 13, clocks E held low after the fall (cycle at least 560 ns).
REQ-004 SHALL have parameter MAX_POLLS, default 255, limit on status reads in poll mode.
REQ-005 SHALL have the following ports, one per line as name, direction, width, meaning:
  iCLK_50MHZ  in  1  single clock, 50 MHz.
  iRST_N  in  1  asynchronous active-low reset.
  iStart  in  1  request pulse; sampled only in IDLE.
  iRS  in  1  0 = status read (BF + address), 1 = data read.
  iPoll  in  1  with iStart and iRS=0: repeat status reads until BF=0.
  oReady  out  1  high in IDLE.
  oDone  out  1  one-cycle pulse when a result is valid.
  oData  out  8  last byte sampled.
  oBusyFlag  out  1  bit 7 of the last status read.
  oAddr  out  7  bits 6:0 of the last status read.
  oTimeout  out  1  one-cycle pulse when poll limit is reached, coincident with oDone.
  DATA_BUS  inout  8  LCD data bus; this block never drives it (always high-Z).
  LCD_RW  out  1  1 during a transaction, else 0.
  LCD_E  out  1  LCD enable strobe.
  LCD_RS  out  1  register select, latched from iRS.

Function
REQ-006 SHALL implement states IDLE, SETUP, EHIGH, ELOW, DONE with one shared down-counter.
REQ-007 IDLE -> SETUP on iStart; latch iRS and iPoll; assert LCD_RW=1 and LCD_RS=latched RS in the same edge.
REQ-008 SETUP SHALL last exactly T_AS cycles with E=0, then go to EHIGH.
REQ-009 EHIGH SHALL hold E=1 for exactly T_EH cycles.
REQ-010 DATA_BUS SHALL be sampled into oData on the last EHIGH cycle, i.e. the edge where E falls.
REQ-011 On a status read, oBusyFlag and oAddr SHALL update from that same sample.
REQ-012 ELOW SHALL hold E=0 for T_EL cycles with RW and RS unchanged (hold time).
REQ-013 After ELOW: if poll mode is active, BF=1, and poll count < MAX_POLLS, go to SETUP and increment the count; otherwise go to DONE.
REQ-014 DONE SHALL last one cycle: oDone=1, oTimeout=1 only if the poll limit ended the read, LCD_RW=0; next state is IDLE.
REQ-015 iStart outside IDLE SHALL be ignored; no queuing.
REQ-016 iPoll with iRS=1 SHALL be treated as a single data read.
REQ-017 The poll counter SHALL be 8 bits, cleared on each accepted iStart, and SHALL never wrap.
REQ-018 Total latency for a single read SHALL be 1 + T_AS + T_EH + T_EL + 1 cycles from the iStart edge to oDone.
REQ-019 LCD_E SHALL be a registered output, free of glitches.

Reset
REQ-020 iRST_N low SHALL force IDLE immediately, at any point including mid-EHIGH.
REQ-021 Reset values: LCD_E=0, LCD_RW=0, LCD_RS=0, oData=0, oBusyFlag=0, oAddr=0, oDone=0, oTimeout=0, oReady=1, counters=0.
REQ-022 A transaction aborted by reset SHALL produce no oDone.

Structure
REQ-023 A shared package SHALL hold the state enum and the default timing constants, which are shared with the LCD write controller.
REQ-024 A sub-module, lcd_strobe_timer, SHALL contain the loadable down-counter with a zero flag.
REQ-025 The bus direction decision SHALL stay at the top level of this block.

Verification
REQ-026 Status read: iStart, iRS=0, bus model returns 8'h85 -> oDone at cycle 30, oBusyFlag=1, oAddr=7'h05, E high for exactly 12 cycles.
REQ-027 Data read: iRS=1, bus model returns 8'h41 -> oData=8'h41, LCD_RS=1 throughout, DATA_BUS stays high-Z.
REQ-028 Poll mode: bus returns BF=1 for 3 reads, then 8'h00 -> four E pulses, single oDone, oTimeout=0.
REQ-029 Poll timeout: BF stuck at 1, MAX_POLLS=4 -> five E pulses, then oDone=1 and oTimeout=1.
REQ-030 Reset asserted during the 5th EHIGH cycle -> E=0 and RW=0 asynchronously, no oDone, oReady=1.
REQ-031 iStart held high continuously -> back-to-back transactions, each separated by one IDLE cycle; no extra E pulses.
